// File: rtl/truth_table_reader_pkg.sv
// Shared definitions for the truth-table scanner.
//   VEC_COUNT : number of input vectors scanned (all 4-input combinations)
//   IDX_W     : width of the vector index / stimulus bus
//   CNT_W     : width of the ones counter (must hold 0..VEC_COUNT)
//   state_e   : scanner FSM state encoding
package truth_table_reader_pkg;

    localparam int VEC_COUNT = 16;
    localparam int IDX_W     = 4;
    localparam int CNT_W     = $clog2(VEC_COUNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/truth_table_reader_settle_timer.sv
// settle_timer: loadable down-counter with a zero flag, used to hold each
// stimulus vector for a programmable number of idle cycles.
// Ports:
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   load_i     : load load_val_i into the counter (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one; saturates at zero
//   zero_o     : counter currently reads zero
module settle_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_reader.sv
// truth_table_reader: walks a 4-input combinational function through all 16
// input vectors, captures its output into a truth table, counts the ones and
// flags the first vector that disagrees with a golden table.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; results from the last scan are held
// SETTLE | stimulus driven, waiting SETTLE cycles for r to settle
// SAMPLE | capture r for the current index, compare against expected
// DONE   | one-cycle completion pulse, then back to IDLE
//
// Ports:
//   clk_i        : clock
//   rst_i        : synchronous active-high reset, aborts a scan
//   start_i      : request a full scan (only honoured in IDLE)
//   expected_i   : golden table, bit i = expected r for index i
//   r_i          : output of the function under test
//   a_o..d_o     : registered stimulus, index = {a,b,c,d}, a = MSB
//   busy_o       : scan in progress (SETTLE/SAMPLE/DONE)
//   done_o       : one-cycle pulse at scan completion
//   table_o      : captured truth table
//   ones_cnt_o   : number of set bits in table_o
//   mismatch_o   : sticky, some sample differed from expected_i
//   fail_idx_o   : first mismatching index, valid while mismatch_o = 1
module truth_table_reader
    import truth_table_reader_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [VEC_COUNT-1:0] expected_i,
    input  logic                 r_i,
    output logic                 a_o,
    output logic                 b_o,
    output logic                 c_o,
    output logic                 d_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [VEC_COUNT-1:0] table_o,
    output logic [CNT_W-1:0]     ones_cnt_o,
    output logic                 mismatch_o,
    output logic [IDX_W-1:0]     fail_idx_o
);

    localparam logic [3:0]       SETTLE_VAL = 4'(SETTLE);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(VEC_COUNT - 1);

    state_e                state_q,  state_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [VEC_COUNT-1:0]  table_q,  table_d;
    logic [CNT_W-1:0]      ones_q,   ones_d;
    logic                  mis_q,    mis_d;
    logic [IDX_W-1:0]      fidx_q,   fidx_d;

    logic tmr_load;
    logic tmr_dec;
    logic tmr_zero;

    settle_timer #(
        .W (4)
    ) u_settle_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (SETTLE_VAL),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        table_d  = table_q;
        ones_d   = ones_q;
        mis_d    = mis_q;
        fidx_d   = fidx_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_SETTLE;
                    idx_d    = '0;
                    table_d  = '0;
                    ones_d   = '0;
                    mis_d    = 1'b0;
                    fidx_d   = '0;
                    tmr_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                // The zero check happens on the counter's current value, so
                // SETTLE = 0 spends exactly one cycle here.
                if (tmr_zero) begin
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                table_d[idx_q] = r_i;
                if (r_i) begin
                    ones_d = ones_q + 1'b1;
                end
                // Only the first disagreement is recorded.
                if ((r_i != expected_i[idx_q]) && !mis_q) begin
                    mis_d  = 1'b1;
                    fidx_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d    = idx_q + 1'b1;
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            table_q <= '0;
            ones_q  <= '0;
            mis_q   <= 1'b0;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            table_q <= table_d;
            ones_q  <= ones_d;
            mis_q   <= mis_d;
            fidx_q  <= fidx_d;
        end
    end

    // The stimulus is the index register itself, so it only moves when the
    // index does: on entry to SETTLE.
    assign {a_o, b_o, c_o, d_o} = idx_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign table_o    = table_q;
    assign ones_cnt_o = ones_q;
    assign mismatch_o = mis_q;
    assign fail_idx_o = fidx_q;

endmodule

// File: tb/tb_truth_table_reader.sv
module tb_truth_table_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [15:0] exp_v = 16'h0000;
    logic [15:0] fn_v  = 16'h0000;
    logic        sel   = 1'b0;

    logic a0, b0, c0, d0, busy0, done0, mis0;
    logic a1, b1, c1, d1, busy1, done1, mis1;
    logic [15:0] tbl0, tbl1;
    logic [4:0]  ones0, ones1;
    logic [3:0]  fidx0, fidx1;
    logic        r0, r1;

    assign r0 = fn_v[{a0, b0, c0, d0}];
    assign r1 = fn_v[{a1, b1, c1, d1}];

    truth_table_reader #(.SETTLE(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .expected_i(exp_v), .r_i(r0),
        .a_o(a0), .b_o(b0), .c_o(c0), .d_o(d0), .busy_o(busy0), .done_o(done0),
        .table_o(tbl0), .ones_cnt_o(ones0), .mismatch_o(mis0), .fail_idx_o(fidx0)
    );

    truth_table_reader #(.SETTLE(0)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .expected_i(exp_v), .r_i(r1),
        .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1), .busy_o(busy1), .done_o(done1),
        .table_o(tbl1), .ones_cnt_o(ones1), .mismatch_o(mis1), .fail_idx_o(fidx1)
    );

    logic [3:0]  abcd_s;
    logic        busy_s, done_s, mis_s;
    logic [15:0] tbl_s;
    logic [4:0]  ones_s;
    logic [3:0]  fidx_s;
    assign abcd_s = sel ? {a1, b1, c1, d1} : {a0, b0, c0, d0};
    assign busy_s = sel ? busy1 : busy0;
    assign done_s = sel ? done1 : done0;
    assign mis_s  = sel ? mis1  : mis0;
    assign tbl_s  = sel ? tbl1  : tbl0;
    assign ones_s = sel ? ones1 : ones0;
    assign fidx_s = sel ? fidx1 : fidx0;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // One scan on the selected DUT. k counts edges after the accepting edge;
    // samples are taken 1 time unit after each edge.
    task automatic run_scan(input int per, output int done_k, output int done_cnt,
                            output int trace_err);
        @(negedge clk);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        done_k = -1;
        done_cnt = 0;
        trace_err = 0;
        for (int k = 0; k <= 60; k++) begin
            if (done_s) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if ((k < 16 * per) && (int'(abcd_s) != k / per)) trace_err++;
            if (busy_s != (k <= 16 * per)) trace_err++;
            // A mid-scan start must be ignored.
            if (k == 5) begin
                if (sel) start1 = 1'b1; else start0 = 1'b1;
            end else begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic        sel;
        logic [15:0] fn;
        logic [15:0] expv;
        logic [15:0] tbl;
        logic [4:0]  ones;
        logic        mis;
        logic [3:0]  fidx;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int dk, dc, te, per, seen, pos[$];
        vecs[0] = '{1'b0, 16'h1894, 16'h1894, 16'h1894, 5'd5,  1'b0, 4'd0};
        vecs[1] = '{1'b0, 16'h1894, 16'h1896, 16'h1894, 5'd5,  1'b1, 4'd1};
        vecs[2] = '{1'b0, 16'h1894, 16'h9894, 16'h1894, 5'd5,  1'b1, 4'd15};
        vecs[3] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 5'd0,  1'b0, 4'd0};
        vecs[4] = '{1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 5'd16, 1'b1, 4'd0};
        vecs[5] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 5'd16, 1'b0, 4'd0};
        vecs[6] = '{1'b1, 16'h1894, 16'h0894, 16'h1894, 5'd5,  1'b1, 4'd12};
        vecs[7] = '{1'b0, 16'hA5A5, 16'h5A5A, 16'hA5A5, 5'd8,  1'b1, 4'd0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_dut0", {a0, b0, c0, d0, busy0, done0, tbl0, ones0, mis0, fidx0}, 32'h0);
        check("reset_dut1", {a1, b1, c1, d1, busy1, done1, tbl1, ones1, mis1, fidx1}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            sel   = vecs[v].sel;
            fn_v  = vecs[v].fn;
            exp_v = vecs[v].expv;
            per   = vecs[v].sel ? 2 : 3;
            run_scan(per, dk, dc, te);
            check($sformatf("v%0d_done_latency", v), 32'(dk), 32'(16 * per));
            check($sformatf("v%0d_done_count", v), 32'(dc), 32'd1);
            check($sformatf("v%0d_trace_busy", v), 32'(te), 32'd0);
            check($sformatf("v%0d_table", v), 32'(tbl_s), 32'(vecs[v].tbl));
            check($sformatf("v%0d_ones", v), 32'(ones_s), 32'(vecs[v].ones));
            check($sformatf("v%0d_mismatch", v), 32'(mis_s), 32'(vecs[v].mis));
            if (vecs[v].mis) check($sformatf("v%0d_fail_idx", v), 32'(fidx_s), 32'(vecs[v].fidx));
        end

        // start held high: back-to-back scans, done spaced 16*3+2 apart.
        sel = 1'b0; fn_v = 16'h1894; exp_v = 16'h1894;
        @(negedge clk);
        start0 = 1'b1;
        for (int k = 0; k < 170; k++) begin
            @(posedge clk); #1;
            if (done0) pos.push_back(k);
        end
        @(negedge clk);
        start0 = 1'b0;
        check("cont_done_pulses", 32'(pos.size()), 32'd3);
        if (pos.size() >= 3) begin
            check("cont_spacing_1", 32'(pos[1] - pos[0]), 32'd50);
            check("cont_spacing_2", 32'(pos[2] - pos[1]), 32'd50);
        end
        repeat (60) @(posedge clk);

        // Reset during vector 7 aborts the scan.
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if ({a0, b0, c0, d0} == 4'd7) begin
                seen = 1;
                break;
            end
        end
        check("reach_vector7", 32'(seen), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_midscan_outputs", {a0, b0, c0, d0, busy0, done0, tbl0, ones0, mis0, fidx0}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        dc = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (done0 || busy0) dc++;
        end
        check("rst_no_done", 32'(dc), 32'd0);
        fn_v = 16'h1894; exp_v = 16'h1896;
        run_scan(3, dk, dc, te);
        check("post_rst_latency", 32'(dk), 32'd48);
        check("post_rst_trace", 32'(te), 32'd0);
        check("post_rst_table", 32'(tbl0), 32'h1894);
        check("post_rst_fail_idx", {27'd0, mis0, fidx0}, {27'd0, 1'b1, 4'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
